lc3_mem_ctrl: RTL and testbench
===============================

Name: lc3_mem_ctrl

Overview:
- Memory/I-O access controller between the SLC3 datapath (MAR/MDR, memory-enable FSM signals) and the external 16-bit asynchronous SRAM.
- Sequences the active-low SRAM strobes with a programmable wait-state count and drives the shared tristate data bus on writes.
- Maps address 16'hFFFF to I/O: reads return switches S; writes load the hex-display register.
- Returns a level ready (R) to the CPU control FSM using a 4-phase handshake.

Parameters:
WAIT_STATES, 2, extra cycles the SRAM read/write strobe is held beyond the minimum 1 cycle; legal range 0..15
IO_ADDR, 16'hFFFF, address decoded as the switch/hex I/O port

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-low reset
Rd_En  in  1  CPU read request, held until Mem_Ready
Wr_En  in  1  CPU write request, held until Mem_Ready
MAR  in  16  word address
MDR_in  in  16  write data from CPU
Data_to_CPU  out  16  registered read data
Mem_Ready  out  1  access complete (level)
S  in  16  board switches
Hex_Data  out  16  hex-display register, feeds HEX0..HEX3 decoders
A  out  20  SRAM address
CE_out, OE_out, WE_out, UB_out, LB_out  out  1 each  SRAM strobes, active-low
Mem_bus  inout  16  SRAM data bus

Behaviour:
- Reset (async, Reset=0), regardless of state:
  - state=IDLE; all strobes 1; Mem_bus='Z.
  - A=0, Data_to_CPU=0, Hex_Data=0, Mem_Ready=0, wait counter=0.
  - Reset mid-access aborts immediately; no partial write may follow release.
- IDLE:
  - Samples Rd_En/Wr_En each cycle.
  - Rd_En has priority if both are high; that write is dropped, not queued.
  - On accept, latch A={4'h0,MAR} and latch MDR_in into an internal write register.
- I/O path (MAR==IO_ADDR):
  - No SRAM strobe asserts; CE stays 1.
  - Read: Data_to_CPU<=S at accept edge. Write: Hex_Data<=MDR_in at accept edge.
  - Next state DONE, so Mem_Ready rises 1 cycle after accept.
- SRAM read: IDLE -> RD_STROBE (WAIT_STATES+1 cycles) -> DONE.
  - In RD_STROBE: CE=OE=UB=LB=0, WE=1, Mem_bus='Z.
  - Data_to_CPU<=Mem_bus on the last RD_STROBE edge.
  - Mem_Ready first high WAIT_STATES+2 cycles after accept.
- SRAM write: IDLE -> WR_SETUP (1 cycle) -> WR_PULSE (WAIT_STATES+1 cycles) -> WR_HOLD (1 cycle) -> DONE.
  - CE=UB=LB=0 in all three states; OE=1 throughout.
  - WE=0 only in WR_PULSE.
  - Mem_bus driven with the latched write data in all three states, 'Z otherwise.
  - Mem_Ready first high WAIT_STATES+4 cycles after accept.
- Bus rules:
  - OE=0 and Mem_bus driving are never simultaneous.
  - WE never falls in the same cycle the bus starts driving; it never rises after the bus stops.
- DONE:
  - All strobes 1; Mem_Ready=1.
  - Remains in DONE until Rd_En==0 and Wr_En==0, then goes to IDLE with Mem_Ready=0.
  - Guarantees one access per request even if the CPU holds its enable.
- Wait counter: 4-bit, loaded with WAIT_STATES on entry to RD_STROBE/WR_PULSE; decrements; exits at 0.
- Data_to_CPU and Hex_Data hold their values between accesses. Data_to_CPU is unchanged by writes.
- Request changes in non-IDLE states, other than the DONE release, are ignored.

Decomposition:
- Package lc3_mem_pkg holds:
  - state enum {IDLE, RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD, DONE}
  - IO_SW_ADDR constant
  - STROBE_OFF=5'b11111 constant for {CE,OE,WE,UB,LB}
- No sub-module required. FSM, counter, I/O registers and the tristate assign stay in one module of about 180 lines.

Test Plan (WAIT_STATES=2, SRAM behavioural model on Mem_bus):
- Reset=0 for 2 cycles, then 1 -> all strobes 1, Mem_bus Z, Hex_Data=0, Mem_Ready=0.
- Preload SRAM[0x0030]=16'hBEEF; Rd_En=1, MAR=0x0030 -> CE/OE low 3 cycles, A=0x00030, Mem_Ready high 4 cycles after accept, Data_to_CPU=16'hBEEF; Mem_Ready holds until Rd_En=0.
- Wr_En=1, MAR=0x0031, MDR_in=16'h1234 -> WE low exactly 3 cycles inside 5-cycle bus drive; SRAM[0x31]=16'h1234; Mem_Ready after 6 cycles; OE never low.
- S=16'h000B, Rd_En, MAR=0xFFFF -> no CE assertion, Data_to_CPU=16'h000B, Mem_Ready after 1 cycle. Wr_En, MAR=0xFFFF, MDR_in=16'h0014 -> Hex_Data=16'h0014, SRAM untouched.
- Rd_En and Wr_En both high, MAR=0x0030 -> read performed, SRAM[0x30] unchanged, WE stays 1.
- Write to 0x0040 with Reset pulsed low during WR_PULSE -> strobes 1 and bus Z immediately; after release, state IDLE and Mem_Ready=0.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared FSM encoding and constants for the SLC3 memory/I-O controller.
// Rev 1.0
`default_nettype none

package lc3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_STROBE = 3'd1,
    WR_SETUP  = 3'd2,
    WR_PULSE  = 3'd3,
    WR_HOLD   = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [15:0] IO_SW_ADDR = 16'hFFFF;

  // Bit order {CE, OE, WE, UB, LB}, all active-low.
  localparam logic [4:0] STROBE_OFF  = 5'b11111;
  localparam logic [4:0] STROBE_RD   = 5'b00100;
  localparam logic [4:0] STROBE_WBUS = 5'b01100;
  localparam logic [4:0] STROBE_WE   = 5'b01000;

endpackage

`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: SLC3 MAR/MDR to async SRAM sequencer with wait states and switch/hex I/O port.
// Rev 1.0
`default_nettype none

module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = IO_SW_ADDR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Rd_En,
  input  logic        Wr_En,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_in,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  input  logic [15:0] S,
  output logic [15:0] Hex_Data,
  output logic [19:0] A,
  output logic        CE_out,
  output logic        OE_out,
  output logic        WE_out,
  output logic        UB_out,
  output logic        LB_out,
  inout  wire  [15:0] Mem_bus
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [15:0] hex_q;
  logic [4:0]  strobe;
  logic        bus_drive;
  logic        is_io;
  logic        accept_rd;
  logic        accept_wr;

  assign is_io     = (MAR == IO_ADDR);
  // Read wins a simultaneous request; the write is dropped.
  assign accept_rd = (state_q == IDLE) && Rd_En;
  assign accept_wr = (state_q == IDLE) && Wr_En && !Rd_En;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (accept_rd) begin
          state_d = is_io ? DONE : RD_STROBE;
          wcnt_d  = WS_INIT;
        end else if (accept_wr) begin
          state_d = is_io ? DONE : WR_SETUP;
        end
      end
      RD_STROBE: begin
        if (wcnt_q == 4'd0) state_d = DONE;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        wcnt_d  = WS_INIT;
      end
      WR_PULSE: begin
        if (wcnt_q == 4'd0) state_d = WR_HOLD;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      WR_HOLD: state_d = DONE;
      DONE: begin
        // Stay here until the CPU drops its enable so one request yields one access.
        if (!Rd_En && !Wr_En) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    strobe    = STROBE_OFF;
    bus_drive = 1'b0;
    case (state_q)
      RD_STROBE: strobe = STROBE_RD;
      WR_SETUP, WR_HOLD: begin
        strobe    = STROBE_WBUS;
        bus_drive = 1'b1;
      end
      WR_PULSE: begin
        strobe    = STROBE_WE;
        bus_drive = 1'b1;
      end
      default: begin
        strobe    = STROBE_OFF;
        bus_drive = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
    end else begin
      if (accept_rd || accept_wr) begin
        addr_q  <= {4'h0, MAR};
        wdata_q <= MDR_in;
      end
      if (accept_rd && is_io) rdata_q <= S;
      if (accept_wr && is_io) hex_q   <= MDR_in;
      if ((state_q == RD_STROBE) && (wcnt_q == 4'd0)) rdata_q <= Mem_bus;
    end
  end

  assign Mem_bus     = bus_drive ? wdata_q : 16'hzzzz;
  assign {CE_out, OE_out, WE_out, UB_out, LB_out} = strobe;
  assign A           = addr_q;
  assign Data_to_CPU = rdata_q;
  assign Hex_Data    = hex_q;
  assign Mem_Ready   = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: directed checks of lc3_mem_ctrl against a small behavioural SRAM.
// Rev 1.0
`default_nettype none

module tb_lc3_mem_ctrl;

  logic        Clk    = 1'b0;
  logic        Reset  = 1'b1;
  logic        Rd_En  = 1'b0;
  logic        Wr_En  = 1'b0;
  logic [15:0] MAR    = '0;
  logic [15:0] MDR_in = '0;
  logic [15:0] S      = '0;
  wire  [15:0] Data_to_CPU;
  wire         Mem_Ready;
  wire  [15:0] Hex_Data;
  wire  [19:0] A;
  wire         CE_out, OE_out, WE_out, UB_out, LB_out;
  wire  [15:0] Mem_bus;

  lc3_mem_ctrl #(.WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Rd_En(Rd_En), .Wr_En(Wr_En), .MAR(MAR), .MDR_in(MDR_in),
    .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready), .S(S), .Hex_Data(Hex_Data), .A(A),
    .CE_out(CE_out), .OE_out(OE_out), .WE_out(WE_out), .UB_out(UB_out), .LB_out(LB_out),
    .Mem_bus(Mem_bus)
  );

  always #10 Clk = ~Clk;

  // Behavioural SRAM; the probe pattern shows up only when nobody else drives the bus.
  logic [15:0] mem [256];
  logic        pre_we   = 1'b0;
  logic [7:0]  pre_a    = '0;
  logic [15:0] pre_d    = '0;
  logic        probe_en = 1'b0;

  always @(posedge Clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (!CE_out && !WE_out) mem[A[7:0]] <= Mem_bus;
  end

  assign Mem_bus = (!CE_out && !OE_out && WE_out) ? mem[A[7:0]] :
                   (probe_en ? 16'hA5A5 : 16'hzzzz);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge Clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge Clk);
    pre_we = 1'b0;
  endtask

  // Raises the request and samples each cycle until Mem_Ready; cyc stays -1 on timeout.
  task automatic access(input logic rd, input logic wr, input logic [15:0] mar,
                        input logic [15:0] mdr, output int cyc, output int ce_n,
                        output int oe_n, output int we_n, output int drv_n, output int bad_n);
    cyc = -1; ce_n = 0; oe_n = 0; we_n = 0; drv_n = 0; bad_n = 0;
    @(negedge Clk);
    Rd_En = rd; Wr_En = wr; MAR = mar; MDR_in = mdr;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (!CE_out) ce_n++;
      if (!OE_out) oe_n++;
      if (!WE_out) we_n++;
      if (Mem_bus === mdr) drv_n++;
      if (!WE_out && (Mem_bus !== mdr)) bad_n++;
      if (Mem_Ready) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic finish_access(input string tag);
    int ce_h;
    ce_h = 0;
    repeat (3) begin
      @(negedge Clk);
      if (!CE_out) ce_h++;
    end
    check({tag, "_ready_held"}, Mem_Ready, 1);
    check({tag, "_no_reaccess"}, ce_h, 0);
    Rd_En = 1'b0; Wr_En = 1'b0;
    @(negedge Clk);
    check({tag, "_ready_release"}, Mem_Ready, 0);
  endtask

  int cyc, ce_n, oe_n, we_n, drv_n, bad_n;
  int found, we_after;

  initial begin
    #1 Reset = 1'b0;
    probe_en = 1'b1;
    repeat (2) @(negedge Clk);
    check("rst_strobes", {CE_out, OE_out, WE_out, UB_out, LB_out}, 5'h1F);
    check("rst_bus_z", Mem_bus, 16'hA5A5);
    check("rst_ready", Mem_Ready, 0);
    check("rst_hex", Hex_Data, 16'h0000);
    check("rst_data", Data_to_CPU, 16'h0000);
    check("rst_addr", A, 20'h00000);
    Reset = 1'b1;
    @(negedge Clk);
    check("post_rst_strobes", {CE_out, OE_out, WE_out, UB_out, LB_out}, 5'h1F);
    check("post_rst_ready", Mem_Ready, 0);
    probe_en = 1'b0;

    preload(8'h30, 16'hBEEF);
    preload(8'hFF, 16'h5555);

    access(1'b1, 1'b0, 16'h0030, 16'h0000, cyc, ce_n, oe_n, we_n, drv_n, bad_n);
    check("rd_latency", cyc, 4);
    check("rd_ce_cycles", ce_n, 3);
    check("rd_oe_cycles", oe_n, 3);
    check("rd_we_cycles", we_n, 0);
    check("rd_addr", A, 20'h00030);
    check("rd_data", Data_to_CPU, 16'hBEEF);
    finish_access("rd");

    access(1'b0, 1'b1, 16'h0031, 16'h1234, cyc, ce_n, oe_n, we_n, drv_n, bad_n);
    check("wr_latency", cyc, 6);
    check("wr_we_cycles", we_n, 3);
    check("wr_drive_cycles", drv_n, 5);
    check("wr_we_outside_drive", bad_n, 0);
    check("wr_oe_cycles", oe_n, 0);
    check("wr_addr", A, 20'h00031);
    check("wr_mem", mem[8'h31], 16'h1234);
    check("wr_data_kept", Data_to_CPU, 16'hBEEF);
    finish_access("wr");

    S = 16'h000B;
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000, cyc, ce_n, oe_n, we_n, drv_n, bad_n);
    check("io_rd_latency", cyc, 1);
    check("io_rd_ce", ce_n, 0);
    check("io_rd_data", Data_to_CPU, 16'h000B);
    finish_access("io_rd");

    access(1'b0, 1'b1, 16'hFFFF, 16'h0014, cyc, ce_n, oe_n, we_n, drv_n, bad_n);
    check("io_wr_latency", cyc, 1);
    check("io_wr_ce", ce_n, 0);
    check("io_wr_hex", Hex_Data, 16'h0014);
    check("io_wr_mem_untouched", mem[8'hFF], 16'h5555);
    check("io_wr_data_kept", Data_to_CPU, 16'h000B);
    finish_access("io_wr");

    access(1'b1, 1'b1, 16'h0030, 16'hDEAD, cyc, ce_n, oe_n, we_n, drv_n, bad_n);
    check("both_latency", cyc, 4);
    check("both_we_cycles", we_n, 0);
    check("both_oe_cycles", oe_n, 3);
    check("both_data", Data_to_CPU, 16'hBEEF);
    check("both_mem", mem[8'h30], 16'hBEEF);
    finish_access("both");

    @(negedge Clk);
    Wr_En = 1'b1; MAR = 16'h0040; MDR_in = 16'h7777;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (!WE_out) begin
        found = 1;
        break;
      end
    end
    check("abort_reached_pulse", found, 1);
    #3 Reset = 1'b0;
    probe_en = 1'b1;
    #1;
    check("abort_strobes", {CE_out, OE_out, WE_out, UB_out, LB_out}, 5'h1F);
    check("abort_bus_z", Mem_bus, 16'hA5A5);
    check("abort_ready", Mem_Ready, 0);
    check("abort_addr", A, 20'h00000);
    @(negedge Clk);
    Wr_En = 1'b0;
    Reset = 1'b1;
    probe_en = 1'b0;
    we_after = 0;
    repeat (3) begin
      @(negedge Clk);
      if (!WE_out || !CE_out) we_after++;
    end
    check("abort_no_partial_write", we_after, 0);
    check("abort_ready_after", Mem_Ready, 0);

    S = 16'h0021;
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000, cyc, ce_n, oe_n, we_n, drv_n, bad_n);
    check("abort_idle_latency", cyc, 1);
    check("abort_idle_data", Data_to_CPU, 16'h0021);
    finish_access("abort_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected $finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
